// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: runs the latched EXE/MEM memory access over a req/gnt/rvalid
// handshake, stalls upstream while it is outstanding, and registers the MEM/WB fields.
module mem_stage_ctrl #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_we_in,
  input  logic              mem_re_in,
  input  logic [DATA_W-1:0] alu_res_in,
  input  logic [DATA_W-1:0] store_data_in,
  input  logic              wr_reg_in,
  output logic              pipe_en,
  output logic              dm_req,
  output logic              dm_we,
  output logic [DATA_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic              dm_gnt,
  input  logic              dm_rvalid,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_we,
  output logic              mem_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t            state, stateNext;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] addrQ, wdataQ;
  logic              weQ;
  logic              op, done, abort, timeoutHit;

  assign op         = mem_we_in | mem_re_in;
  assign timeoutHit = (cnt == CNT_W'(TIMEOUT - 1));

  assign dm_req   = (state == REQ);
  assign dm_we    = weQ;
  assign dm_addr  = addrQ;
  assign dm_wdata = wdataQ;
  assign pipe_en  = done | abort;

  always_comb begin
    stateNext = state;
    done      = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (!op) done = 1'b1;
        else     stateNext = REQ;
      end
      REQ: begin
        // rvalid is only meaningful for a load once the grant has arrived
        if (dm_gnt && (weQ || dm_rvalid)) begin
          done      = 1'b1;
          stateNext = IDLE;
        end else if (dm_gnt) begin
          stateNext = RESP;
        end
      end
      RESP: begin
        if (dm_rvalid) begin
          done      = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
    // completion on the last allowed cycle takes priority over the abort
    if (state != IDLE && !done && timeoutHit) begin
      abort     = 1'b1;
      stateNext = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      addrQ   <= '0;
      wdataQ  <= '0;
      weQ     <= 1'b0;
      wb_data <= '0;
      wb_we   <= 1'b0;
      mem_err <= 1'b0;
    end else begin
      state <= stateNext;
      if (state == IDLE && op) begin
        addrQ  <= alu_res_in;
        wdataQ <= store_data_in;
        weQ    <= mem_we_in;
        cnt    <= '0;
      end else if (state != IDLE) begin
        cnt <= cnt + CNT_W'(1);
      end
      wb_we <= 1'b0;
      if (done) begin
        if (state == IDLE) begin
          wb_data <= alu_res_in;
          wb_we   <= wr_reg_in;
        end else if (!weQ) begin
          wb_data <= dm_rdata;
          wb_we   <= wr_reg_in;
        end
      end
      if (abort) mem_err <= 1'b1;
    end
  end

endmodule
